// File: rtl/branch_resolver_if.sv
// Bundle of ID/EX branch inputs, predictor/fetch feedback and performance counters
// for branch_resolver.
interface branch_resolver_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            stall;
  logic            id_valid;
  logic            id_is_branch;
  logic            id_predicted;
  logic            ex_valid;
  logic            ex_is_branch;
  logic            ex_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            perf_clear;

  logic             wrong_prediction;
  logic             update_valid;
  logic             update_taken;
  logic             flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output stall, id_valid, id_is_branch, id_predicted,
           ex_valid, ex_is_branch, ex_taken, ex_pc, ex_target, perf_clear,
    input  wrong_prediction, update_valid, update_taken, flush,
           redirect_valid, redirect_pc, branch_count, mispredict_count
  );

  modport slave (
    input  stall, id_valid, id_is_branch, id_predicted,
           ex_valid, ex_is_branch, ex_taken, ex_pc, ex_target, perf_clear,
    output wrong_prediction, update_valid, update_taken, flush,
           redirect_valid, redirect_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: trains the 2-bit predictor, flushes and redirects on mispredict.
// Define BRANCH_RESOLVER_PERF_EN to enable the saturating branch/mispredict counters.
//
// state  | meaning
// S_IDLE | resolving branches arriving in EX
// S_FLUSH| flush asserted, down-counter running, EX branches ignored
module branch_resolver #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  branch_resolver_if.slave   br
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_flush_cnt;
  logic [3:0]      w_flush_cnt_next;

  logic            r_pv;
  logic            r_pt;

  logic            r_wrong_prediction;
  logic            r_update_valid;
  logic            r_update_taken;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  logic            w_resolve;
  logic            w_predicted;
  logic            w_mispredict;
  logic            w_flush_next;
  logic [XLEN-1:0] w_fallthrough;
  logic [XLEN-1:0] w_redirect_target;

  // An unmarked branch (no valid capture) is treated as predicted not-taken.
  assign w_resolve         = ~br.stall & br.ex_valid & br.ex_is_branch & (r_state == S_IDLE);
  assign w_predicted       = r_pv & r_pt;
  assign w_mispredict      = w_resolve & (br.ex_taken ^ w_predicted);
  assign w_flush_next      = (w_state_next == S_FLUSH);
  assign w_fallthrough     = br.ex_pc + XLEN'(4);
  assign w_redirect_target = br.ex_taken ? br.ex_target : w_fallthrough;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  // The flush timer runs regardless of stall so the kill window is fixed length.
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_mispredict) begin
          w_state_next     = S_FLUSH;
          w_flush_cnt_next = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt <= 4'd1) begin
          w_state_next     = S_IDLE;
          w_flush_cnt_next = '0;
        end else begin
          w_flush_cnt_next = r_flush_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next     = S_IDLE;
        w_flush_cnt_next = '0;
      end
    endcase
  end

  // Wrong-path branches entering ID while the flush is live are never marked valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv <= 1'b0;
      r_pt <= 1'b0;
    end else if (!br.stall) begin
      r_pv <= br.id_valid & br.id_is_branch & ~w_flush_next;
      r_pt <= br.id_predicted;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_update_valid     <= 1'b0;
      r_update_taken     <= 1'b0;
      r_wrong_prediction <= 1'b0;
      r_redirect_valid   <= 1'b0;
      r_redirect_pc      <= '0;
    end else begin
      r_update_valid     <= w_resolve;
      r_update_taken     <= w_resolve & br.ex_taken;
      r_wrong_prediction <= w_mispredict;
      r_redirect_valid   <= w_mispredict;
      if (w_mispredict) begin
        r_redirect_pc <= w_redirect_target;
      end
    end
  end

  assign br.update_valid     = r_update_valid;
  assign br.update_taken     = r_update_taken;
  assign br.wrong_prediction = r_wrong_prediction;
  assign br.redirect_valid   = r_redirect_valid;
  assign br.redirect_pc      = r_redirect_pc;
  assign br.flush            = (r_state == S_FLUSH);

`ifdef BRANCH_RESOLVER_PERF_EN
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  // Clear has priority over a same-cycle resolve; counters stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (br.perf_clear) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_resolve) begin
      if (r_branch_count != '1) begin
        r_branch_count <= r_branch_count + CNT_W'(1);
      end
      if (w_mispredict && (r_mispredict_count != '1)) begin
        r_mispredict_count <= r_mispredict_count + CNT_W'(1);
      end
    end
  end

  assign br.branch_count     = r_branch_count;
  assign br.mispredict_count = r_mispredict_count;
`else
  logic w_unused_perf;

  assign w_unused_perf       = br.perf_clear;
  assign br.branch_count     = '0;
  assign br.mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table, corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_branch_resolver;

  localparam int FC    = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef BRANCH_RESOLVER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  branch_resolver_if #(.XLEN(32), .CNT_W(CNT_W)) br ();

  branch_resolver #(
    .XLEN        (32),
    .FLUSH_CYCLES(FC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .br   (br.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining flush cycles, captured prediction, expected outputs.
  int          m_left;
  bit          m_pv;
  bit          m_pt;
  bit          e_uv, e_ut, e_wp, e_rv, e_fl;
  logic [31:0] e_rpc;
  int          e_bc, e_mc;

  typedef struct {
    bit          st, idv, idb, idp, exv, exb, ext;
    logic [31:0] pc, tgt;
    bit          uv, ut, wp, fl, rv;
    logic [31:0] rpc;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_pv = 0; m_pt = 0;
    e_uv = 0; e_ut = 0; e_wp = 0; e_rv = 0; e_fl = 0;
    e_rpc = '0; e_bc = 0; e_mc = 0;
  endtask

  task automatic model_edge();
    bit res, pred, mis, fn;
    int left_n;
    res  = !br.stall && br.ex_valid && br.ex_is_branch && (m_left == 0);
    pred = m_pv && m_pt;
    mis  = res && (br.ex_taken != pred);
    if (mis)             left_n = FC;
    else if (m_left > 0) left_n = m_left - 1;
    else                 left_n = 0;
    fn = (left_n > 0);
    if (!br.stall) begin
      m_pv = br.id_valid && br.id_is_branch && !fn;
      m_pt = br.id_predicted;
    end
    e_uv = res;
    e_ut = res && br.ex_taken;
    e_wp = mis;
    e_rv = mis;
    if (mis) e_rpc = br.ex_taken ? br.ex_target : br.ex_pc + 32'd4;
    if (PERF) begin
      if (br.perf_clear) begin
        e_bc = 0; e_mc = 0;
      end else if (res) begin
        if (e_bc < CMAX) e_bc++;
        if (mis && e_mc < CMAX) e_mc++;
      end
    end
    m_left = left_n;
    e_fl   = fn;
  endtask

  task automatic set_in(input bit st, input bit idv, input bit idb, input bit idp,
                        input bit exv, input bit exb, input bit ext,
                        input logic [31:0] pc, input logic [31:0] tgt, input bit clr);
    @(negedge clk);
    br.stall = st; br.id_valid = idv; br.id_is_branch = idb; br.id_predicted = idp;
    br.ex_valid = exv; br.ex_is_branch = exb; br.ex_taken = ext;
    br.ex_pc = pc; br.ex_target = tgt; br.perf_clear = clr;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".update_valid"},     32'(br.update_valid),     32'(e_uv));
    chk({tag, ".update_taken"},     32'(br.update_taken),     32'(e_ut));
    chk({tag, ".wrong_prediction"}, 32'(br.wrong_prediction), 32'(e_wp));
    chk({tag, ".redirect_valid"},   32'(br.redirect_valid),   32'(e_rv));
    chk({tag, ".flush"},            32'(br.flush),            32'(e_fl));
    chk({tag, ".redirect_pc"},      br.redirect_pc,           e_rpc);
    chk({tag, ".branch_count"},     32'(br.branch_count),     32'(e_bc));
    chk({tag, ".mispredict_count"}, 32'(br.mispredict_count), 32'(e_mc));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    br.stall = 0; br.id_valid = 0; br.id_is_branch = 0; br.id_predicted = 0;
    br.ex_valid = 0; br.ex_is_branch = 0; br.ex_taken = 0;
    br.ex_pc = '0; br.ex_target = '0; br.perf_clear = 0;
    reset = 1'b1;

    //            st idv idb idp exv exb ext pc            tgt        uv ut wp fl rv rpc
    tbl[0]  = '{0, 1, 1, 1, 0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 0, 0, 32'h0};
    tbl[1]  = '{0, 0, 0, 0, 1, 1, 1, 32'h0,        32'h100,  1, 1, 0, 0, 0, 32'h0};
    tbl[2]  = '{0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 0, 0, 32'h0};
    tbl[3]  = '{0, 1, 1, 1, 1, 1, 1, 32'h40,       32'h80,   1, 1, 1, 1, 1, 32'h80};
    tbl[4]  = '{0, 0, 0, 0, 1, 1, 0, 32'h44,       32'h90,   0, 0, 0, 1, 0, 32'h80};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 0, 0, 32'h80};
    tbl[6]  = '{0, 1, 1, 1, 0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 0, 0, 32'h80};
    tbl[7]  = '{0, 0, 0, 0, 1, 1, 0, 32'hFFFFFFFC, 32'h1234, 1, 0, 1, 1, 1, 32'h0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 1, 0, 32'h0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 0, 0, 32'h0};
    tbl[10] = '{0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 0, 0, 32'h0};
    tbl[11] = '{1, 0, 0, 0, 1, 1, 1, 32'h200,      32'h300,  0, 0, 0, 0, 0, 32'h0};
    tbl[12] = '{1, 0, 0, 0, 1, 1, 1, 32'h200,      32'h300,  0, 0, 0, 0, 0, 32'h0};
    tbl[13] = '{1, 0, 0, 0, 1, 1, 1, 32'h200,      32'h300,  0, 0, 0, 0, 0, 32'h0};
    tbl[14] = '{0, 0, 0, 0, 1, 1, 1, 32'h200,      32'h300,  1, 1, 1, 1, 1, 32'h300};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 1, 0, 32'h300};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 0, 0, 32'h300};
    tbl[17] = '{0, 0, 0, 0, 1, 0, 1, 32'h10,       32'h20,   0, 0, 0, 0, 0, 32'h300};
    tbl[18] = '{0, 0, 0, 0, 1, 1, 0, 32'h24,       32'h50,   1, 0, 0, 0, 0, 32'h300};

    #1;
    check_model("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      set_in(tbl[i].st, tbl[i].idv, tbl[i].idb, tbl[i].idp, tbl[i].exv, tbl[i].exb,
             tbl[i].ext, tbl[i].pc, tbl[i].tgt, 1'b0);
      cycle();
      chk($sformatf("vec%0d.update_valid", i),     32'(br.update_valid),     32'(tbl[i].uv));
      chk($sformatf("vec%0d.update_taken", i),     32'(br.update_taken),     32'(tbl[i].ut));
      chk($sformatf("vec%0d.wrong_prediction", i), 32'(br.wrong_prediction), 32'(tbl[i].wp));
      chk($sformatf("vec%0d.flush", i),            32'(br.flush),            32'(tbl[i].fl));
      chk($sformatf("vec%0d.redirect_valid", i),   32'(br.redirect_valid),   32'(tbl[i].rv));
      chk($sformatf("vec%0d.redirect_pc", i),      br.redirect_pc,           tbl[i].rpc);
      chk($sformatf("vec%0d.counts", i),
          32'({br.branch_count, br.mispredict_count}), 32'({4'(e_bc), 4'(e_mc)}));
    end

    // Reset arriving mid-flush kills the flush without waiting for a clock.
    set_in(0, 0, 0, 0, 1, 1, 1, 32'h500, 32'h600, 0);
    cycle();
    chk("midflush.flush_before", 32'(br.flush), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midflush.flush_after",  32'(br.flush),          32'd0);
    chk("midflush.redirect_pc",  br.redirect_pc,         32'h0);
    chk("midflush.wrong_pred",   32'(br.wrong_prediction), 32'd0);
    chk("midflush.update_valid", 32'(br.update_valid),   32'd0);
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    reset = 1'b0;

    // 20 resolves, every fourth one mispredicted: branch count saturates, mispredicts do not.
    for (int i = 0; i < 20; i++) begin
      set_in(0, 0, 0, 0, 1, 1, (i % 4 == 0), 32'h1000 + 32'(i * 8), 32'h2000, 0);
      cycle();
      if (i % 4 == 0) begin
        for (int k = 0; k < FC; k++) begin
          set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
          cycle();
        end
      end
    end
    chk("perf.branch_sat",     32'(br.branch_count),     PERF ? 32'd15 : 32'd0);
    chk("perf.mispredict_cnt", 32'(br.mispredict_count), PERF ? 32'd5 : 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    cycle();
    chk("perf.clear_branch",     32'(br.branch_count),     32'd0);
    chk("perf.clear_mispredict", 32'(br.mispredict_count), 32'd0);
    set_in(0, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 0);
    cycle();
    chk("perf.one_resolve", 32'(br.branch_count), PERF ? 32'd1 : 32'd0);
    set_in(0, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 1);
    cycle();
    chk("perf.clear_wins", 32'(br.branch_count), 32'd0);
    chk("perf.clear_wins_update", 32'(br.update_valid), 32'd1);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      set_in($urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 1) == 1, pc, $urandom & 32'hFFFFFFFC,
             $urandom_range(0, 40) == 0);
      cycle();
      check_model($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
